// File: rtl/iob_ram_tdp_arb.sv
// iob_ram_tdp_arb: round-robin arbiter sharing a true dual-port RAM among N_REQ requesters
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_addr/req_wstrb/req_wdata per requester;
// resp_rvalid per requester plus shared resp_rdata; enA/weA/addrA/dinA/doutA and enB/weB/addrB/dinB/doutB to the RAM.
module iob_ram_tdp_arb #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           resp_rvalid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       enA,
  output logic                       enB,
  output logic [DATA_W/8-1:0]        weA,
  output logic [DATA_W/8-1:0]        weB,
  output logic [ADDR_W-1:0]          addrA,
  output logic [ADDR_W-1:0]          addrB,
  output logic [DATA_W-1:0]          dinA,
  output logic [DATA_W-1:0]          dinB,
  input  logic [DATA_W-1:0]          doutA,
  input  logic [DATA_W-1:0]          doutB
);
  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, ptr_n, a_idx, b_idx, kk;
  logic a_ok, b_ok, a_rd, b_rd, gnt_a, gnt_b, sel_q;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [SW-1:0] a_ws, b_ws;
  logic [DATA_W-1:0] a_wd, b_wd;
  logic [N_REQ-1:0] rv_q, rd_gnt;
  int k;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  // first two valid requesters in rotated order starting at ptr
  always_comb begin
    a_ok = 1'b0;
    b_ok = 1'b0;
    a_idx = '0;
    b_idx = '0;
    k = 0;
    kk = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr) + i;
      k = (k >= N_REQ) ? k - N_REQ : k;
      kk = IW'(k);
      if (req_valid[kk] && !a_ok) begin
        a_ok = 1'b1;
        a_idx = kk;
      end else if (req_valid[kk] && !b_ok) begin
        b_ok = 1'b1;
        b_idx = kk;
      end
    end
  end
  always_comb begin
    a_addr = req_addr[int'(a_idx)*ADDR_W +: ADDR_W];
    b_addr = req_addr[int'(b_idx)*ADDR_W +: ADDR_W];
    a_ws = req_wstrb[int'(a_idx)*SW +: SW];
    b_ws = req_wstrb[int'(b_idx)*SW +: SW];
    a_wd = req_wdata[int'(a_idx)*DATA_W +: DATA_W];
    b_wd = req_wdata[int'(b_idx)*DATA_W +: DATA_W];
    a_rd = a_ws == '0;
    b_rd = b_ws == '0;
    gnt_a = rst_n && a_ok;
    // B waits on a same-address hazard with a write, and on a second read since resp_rdata is shared
    gnt_b = gnt_a && b_ok && !(a_rd && b_rd) && ((a_addr != b_addr) || (a_rd && b_rd));
    req_ready = (gnt_a ? N_REQ'(1) << a_idx : '0) | (gnt_b ? N_REQ'(1) << b_idx : '0);
    rd_gnt = (gnt_a && a_rd ? N_REQ'(1) << a_idx : '0) | (gnt_b && b_rd ? N_REQ'(1) << b_idx : '0);
    ptr_n = gnt_b ? nxt(b_idx) : gnt_a ? nxt(a_idx) : ptr;
    enA = gnt_a;
    weA = gnt_a ? a_ws : '0;
    addrA = gnt_a ? a_addr : '0;
    dinA = gnt_a ? a_wd : '0;
    enB = gnt_b;
    weB = gnt_b ? b_ws : '0;
    addrB = gnt_b ? b_addr : '0;
    dinB = gnt_b ? b_wd : '0;
    resp_rvalid = rv_q;
    resp_rdata = (|rv_q) ? (sel_q ? doutB : doutA) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      rv_q <= '0;
      sel_q <= 1'b0;
    end else begin
      ptr <= ptr_n;
      rv_q <= rd_gnt;
      sel_q <= gnt_b && b_rd;
    end
  end
endmodule

// File: tb/tb_iob_ram_tdp_arb.sv
// tb_iob_ram_tdp_arb: self-checking bench with directed scenarios and a randomized reference-model run
module tb_iob_ram_tdp_arb;
  localparam int N = 4, AW = 10, DW = 32, SW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, resp_rvalid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] resp_rdata, dinA, dinB, doutA, doutB;
  logic enA, enB;
  logic [SW-1:0] weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:7];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  iob_ram_tdp_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_rvalid(resp_rvalid), .resp_rdata(resp_rdata),
    .enA(enA), .enB(enB), .weA(weA), .weB(weB), .addrA(addrA), .addrB(addrB),
    .dinA(dinA), .dinB(dinB), .doutA(doutA), .doutB(doutB));
  // read-first dual-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (enA) begin
      doutA <= mem[addrA];
      for (int j = 0; j < SW; j++) if (weA[j]) mem[addrA][8*j +: 8] <= dinA[8*j +: 8];
    end
    if (enB) begin
      doutB <= mem[addrB];
      for (int j = 0; j < SW; j++) if (weB[j]) mem[addrB][8*j +: 8] <= dinB[8*j +: 8];
    end
  end
  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    req_valid[k] = v;
    req_addr[k*AW +: AW] = a;
    req_wstrb[k*SW +: SW] = s;
    req_wdata[k*DW +: DW] = d;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, AW'(k), '0, '0);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++;
    if ({enA, enB, weA, weB} !== '0) begin failures++; $display("FAIL reset_ports: got %b want 0", {enA, enB, weA, weB}); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_rvalid, resp_rdata} !== '0) begin failures++; $display("FAIL reset_resp: got %b/%h want 0/0", resp_rvalid, resp_rdata); end
    req_valid = '0;
    #1 rst_n = 1'b1;
    next_cycle();
  endtask
  task automatic test_single_read();
    mem[5] = 32'hDEADBEEF;
    do_reset();
    set_req(0, 1'b1, 10'd5, 4'h0, '0);
    @(negedge clk);
    checks++;
    if ({req_ready, enA, addrA, enB} !== {4'b0001, 1'b1, 10'd5, 1'b0}) begin failures++; $display("FAIL read_grant: got rdy=%b enA=%b addrA=%0d enB=%b want 0001 1 5 0", req_ready, enA, addrA, enB); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({resp_rvalid, resp_rdata} !== {4'b0001, 32'hDEADBEEF}) begin failures++; $display("FAIL read_data: got %b/%h want 0001/deadbeef", resp_rvalid, resp_rdata); end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({resp_rvalid, resp_rdata} !== '0) begin failures++; $display("FAIL read_pulse: got %b/%h want 0/0", resp_rvalid, resp_rdata); end
    next_cycle();
  endtask
  task automatic test_write_read_pair();
    mem[7] = 32'hCAFE0007;
    mem[3] = 32'h33333333;
    do_reset();
    set_req(1, 1'b1, 10'd3, 4'h1, 32'h000000AA);
    set_req(2, 1'b1, 10'd7, 4'h0, '0);
    @(negedge clk);
    checks++;
    if ({req_ready, enA, weA, addrA, dinA, enB, weB, addrB} !== {4'b0110, 1'b1, 4'h1, 10'd3, 32'hAA, 1'b1, 4'h0, 10'd7}) begin failures++; $display("FAIL pair_grant: got rdy=%b A=%b/%h/%0d/%h B=%b/%h/%0d", req_ready, enA, weA, addrA, dinA, enB, weB, addrB); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({resp_rvalid, resp_rdata} !== {4'b0100, 32'hCAFE0007}) begin failures++; $display("FAIL pair_resp: got %b/%h want 0100/cafe0007", resp_rvalid, resp_rdata); end
    checks++;
    if (mem[3] !== 32'h333333AA) begin failures++; $display("FAIL pair_mem: got %h want 333333aa", mem[3]); end
    next_cycle();
  endtask
  task automatic test_write_conflict();
    do_reset();
    set_req(0, 1'b1, 10'd9, 4'hF, 32'h11111111);
    set_req(1, 1'b1, 10'd9, 4'hF, 32'h22222222);
    @(negedge clk);
    checks++;
    if ({req_ready, weA, enB} !== {4'b0001, 4'hF, 1'b0}) begin failures++; $display("FAIL conflict_first: got rdy=%b weA=%h enB=%b want 0001 f 0", req_ready, weA, enB); end
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, enA, addrA, dinA} !== {4'b0010, 1'b1, 10'd9, 32'h22222222}) begin failures++; $display("FAIL conflict_second: got rdy=%b enA=%b addrA=%0d dinA=%h", req_ready, enA, addrA, dinA); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({resp_rvalid, mem[9]} !== {4'b0000, 32'h22222222}) begin failures++; $display("FAIL conflict_mem: got rv=%b mem9=%h want 0000 22222222", resp_rvalid, mem[9]); end
    next_cycle();
  endtask
  task automatic test_back_to_back();
    logic [3:0] prev;
    do_reset();
    for (int k = 0; k < N; k++) begin
      mem[16+k] = 32'hB0B0_0000 + k;
      set_req(k, 1'b1, AW'(16+k), '0, '0);
    end
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      checks++;
      if (c > 0 && {resp_rvalid, resp_rdata} !== {prev, 32'hB0B0_0000 + ((c - 1) % 4)}) begin failures++; $display("FAIL rr_resp%0d: got %b/%h want %b", c, resp_rvalid, resp_rdata, prev); end
      prev = 4'(1 << (c % 4));
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
  endtask
  task automatic test_reset_drop();
    do_reset();
    set_req(0, 1'b1, 10'd5, 4'h0, '0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL drop_grant: got %b want 0001", req_ready); end
    rst_n = 1'b0;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if ({resp_rvalid, resp_rdata} !== '0) begin failures++; $display("FAIL drop_resp: got %b/%h want 0/0", resp_rvalid, resp_rdata); end
    next_cycle();
    rst_n = 1'b1;
    set_req(2, 1'b1, 10'd40, 4'h0, '0);
    set_req(3, 1'b1, 10'd41, 4'h0, '0);
    @(negedge clk);
    checks++;
    if ({req_ready, addrA, enB} !== {4'b0100, 10'd40, 1'b0}) begin failures++; $display("FAIL drop_regrant: got rdy=%b addrA=%0d enB=%b want 0100 40 0", req_ready, addrA, enB); end
    next_cycle();
    req_valid = '0;
    next_cycle();
  endtask
  task automatic test_port_b_read();
    mem[21] = 32'h12345678;
    do_reset();
    set_req(0, 1'b1, 10'd20, 4'hF, 32'h55555555);
    set_req(1, 1'b1, 10'd21, 4'h0, '0);
    @(negedge clk);
    checks++;
    if ({req_ready, enA, weA, enB, addrB} !== {4'b0011, 1'b1, 4'hF, 1'b1, 10'd21}) begin failures++; $display("FAIL portb_grant: got rdy=%b enA=%b weA=%h enB=%b addrB=%0d", req_ready, enA, weA, enB, addrB); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({resp_rvalid, resp_rdata} !== {4'b0010, 32'h12345678}) begin failures++; $display("FAIL portb_resp: got %b/%h want 0010/12345678", resp_rvalid, resp_rdata); end
    next_cycle();
  endtask
  task automatic test_random();
    int mptr, a, b, q[$], wt[N];
    logic [3:0] held, e_rdy, e_rv, n_rv;
    logic [31:0] e_rd, n_rd;
    logic [93:0] e_ports;
    logic [AW-1:0] ad[N];
    logic [SW-1:0] ws[N];
    logic [DW-1:0] wd[N];
    for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];
    do_reset();
    mptr = 0; held = '0; e_rv = '0; e_rd = '0;
    for (int k = 0; k < N; k++) wt[k] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++)
        if (!held[k]) set_req(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                              $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom);
      for (int k = 0; k < N; k++) begin
        ad[k] = req_addr[k*AW +: AW];
        ws[k] = req_wstrb[k*SW +: SW];
        wd[k] = req_wdata[k*DW +: DW];
      end
      @(negedge clk);
      checks++;
      if ({resp_rvalid, resp_rdata} !== {e_rv, e_rd}) begin failures++; $display("FAIL rnd_resp c%0d: got %b/%h want %b/%h", cyc, resp_rvalid, resp_rdata, e_rv, e_rd); end
      q.delete();
      for (int i = 0; i < N; i++) if (req_valid[(mptr + i) % N]) q.push_back((mptr + i) % N);
      a = q.size() > 0 ? q[0] : -1;
      b = q.size() > 1 ? q[1] : -1;
      if (a >= 0 && b >= 0) begin
        if (ws[a] == 0 && ws[b] == 0) b = -1;
        else if (ad[a] == ad[b]) b = -1;
      end
      e_rdy = '0; e_ports = '0; n_rv = '0; n_rd = '0;
      if (a >= 0) begin
        e_rdy[a] = 1'b1;
        e_ports[93:47] = {1'b1, ws[a], ad[a], wd[a]};
        mptr = (a + 1) % N;
        if (ws[a] == 0) begin n_rv[a] = 1'b1; n_rd = ref_mem[ad[a][2:0]]; end
      end
      if (b >= 0) begin
        e_rdy[b] = 1'b1;
        e_ports[46:0] = {1'b1, ws[b], ad[b], wd[b]};
        mptr = (b + 1) % N;
        if (ws[b] == 0) begin n_rv[b] = 1'b1; n_rd = ref_mem[ad[b][2:0]]; end
      end
      checks++;
      if (req_ready !== e_rdy) begin failures++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, req_ready, e_rdy); end
      checks++;
      if ({enA, weA, addrA, dinA, enB, weB, addrB, dinB} !== e_ports) begin failures++; $display("FAIL rnd_ports c%0d: got %h want %h", cyc, {enA, weA, addrA, dinA, enB, weB, addrB, dinB}, e_ports); end
      for (int k = 0; k < N; k++) begin
        if (e_rdy[k] && ws[k] != 0)
          for (int j = 0; j < SW; j++) if (ws[k][j]) ref_mem[ad[k][2:0]][8*j +: 8] = wd[k][8*j +: 8];
        wt[k] = (req_valid[k] && !req_ready[k]) ? wt[k] + 1 : 0;
        checks++;
        if (wt[k] >= N) begin failures++; $display("FAIL rnd_starve c%0d: req %0d waited %0d want <%0d", cyc, k, wt[k], N); end
      end
      held = req_valid & ~e_rdy;
      e_rv = n_rv;
      e_rd = n_rd;
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_write_read_pair();
    test_write_conflict();
    test_back_to_back();
    test_reset_drop();
    test_port_b_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iob_ram_tdp_arb.md
IOB_RAM_TDP_ARB -- requirements
Module: iob_ram_tdp_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 10, RAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, N_REQ, per-requester access request.
REQ-007 SHALL have port req_ready, output, N_REQ, per-requester grant; the access is accepted when valid and ready are both 1.
REQ-008 SHALL have port req_addr, input, N_REQ*ADDR_W, flattened addresses; requester k uses slice k.
REQ-009 SHALL have port req_wstrb, input, N_REQ*DATA_W/8, byte write strobes; all-zero means read.
REQ-010 SHALL have port req_wdata, input, N_REQ*DATA_W, write data.
REQ-011 SHALL have port resp_rvalid, output, N_REQ, read-data-valid pulse.
REQ-012 SHALL have port resp_rdata, output, DATA_W, shared read data, valid only while a resp_rvalid bit is 1.
REQ-013 SHALL have ports enA/enB, output, 1; weA/weB, output, DATA_W/8; addrA/addrB, output, ADDR_W; dinA/dinB, output, DATA_W, which drive the RAM ports.
REQ-014 SHALL have ports doutA/doutB, input, DATA_W, which carry RAM read data (1-cycle latency, read-first).

Function
REQ-015 SHALL grant at most two requesters per cycle: the first winner goes to port A and the second to port B.
REQ-016 SHALL select winners round-robin from pointer ptr: scan indices ptr, ptr+1, ... modulo N_REQ; the first valid index wins A and the next valid index wins B.
REQ-017 SHALL make req_ready, en*, we*, addr*, and din* combinational from req_valid and ptr in the same cycle, with zero-cycle grant latency.
REQ-018 SHALL drive en=0, we=0, and addr/din=0 on any port that has no winner.
REQ-019 SHALL, on an address conflict, grant the B candidate only if addrA != addrB or both wstrb are zero; otherwise the B candidate gets no grant and waits.
REQ-020 SHALL update ptr on any grant to (index of last granted requester + 1) mod N_REQ; with no grant, ptr holds.
REQ-021 SHALL, for a granted read (wstrb==0), pulse resp_rvalid[k] for exactly one cycle, one cycle after the grant.
REQ-022 SHALL drive resp_rdata from doutA or doutB according to the registered port of that grant.
REQ-023 SHALL serialize the shared resp_rdata: when the A winner is a read, a B candidate that is also a read is NOT granted in that cycle, so at most one read returns per cycle.
REQ-024 SHALL NOT produce resp_rvalid for a granted write (wstrb!=0); a write completes at its grant.
REQ-025 SHALL never assert req_ready for a requester whose req_valid is 0.
REQ-026 SHALL guarantee starvation freedom: a requester holding req_valid is granted within N_REQ cycles.
REQ-027 SHALL require requesters to hold addr/wstrb/wdata stable while valid && !ready.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, set ptr=0, clear the registered response state, and force resp_rvalid=0 on the next cycle.
REQ-029 SHALL force req_ready=0, enA=enB=0, and weA=weB=0 combinationally while rst_n=0.
REQ-030 SHALL drop a read granted in the cycle before reset asserts: no resp_rvalid is produced after reset.
REQ-031 SHALL set resp_rdata to 0 whenever resp_rvalid is all zero.

Verification
REQ-032 SHALL cover this scenario: reset, then req 0 reads addr 5 (mem[5]=0xDEADBEEF) → ready[0]=1 and enA=1, addrA=5; the next cycle rvalid[0]=1 and rdata=0xDEADBEEF.
REQ-033 SHALL cover this scenario: req 1 writes addr 3 with wstrb=0x1 and req 2 reads addr 7 in the same cycle with ptr=0 → both granted (A=1 write, B=2 read); rvalid[2] follows next cycle; rvalid[1] is never asserted.
REQ-034 SHALL cover this scenario: req 0 and req 1 both write addr 9 with ptr=0 → only req 0 granted (weA=wstrb0, enB=0); req 1 is granted next cycle and mem[9] ends with req 1's data.
REQ-035 SHALL cover this scenario: all 4 requesters issue continuous reads → grants rotate 0,1,2,3,0 one per cycle, rvalid is one-hot each cycle, and no requester waits more than 4 cycles.
REQ-036 SHALL cover this scenario: a read is granted and rst_n is pulled low on the next edge → no rvalid; after release ptr=0 and the first grant goes to the lowest valid index.
REQ-037 SHALL cover this scenario: a read by requester k is granted on port B → resp_rdata equals doutB, with no contamination from a concurrent port-A write.
